// File: rtl/datatape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datatape_pkg
//  Description : Shared widths, symbol type and decoder state encoding for
//                the datatape video receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package datatape_pkg;

  localparam int SYMBOL_W = 4;
  localparam int FIFO_AW  = 9;

  typedef logic [SYMBOL_W-1:0] symbol_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VSKIP    = 3'd1,
    HSKIP    = 3'd2,
    ACTIVE   = 3'd3,
    LINE_END = 3'd4
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/video_symbol_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : video_symbol_quantizer
//  Description : Combinational round-and-clamp of an 8-bit luma sample to a
//                data symbol. Black level maps to 0, each LEVEL_SHIFT-sized
//                step above it to the next symbol, saturating at the top.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_symbol_quantizer
  import datatape_pkg::*;
#(
  parameter int BLACK_LEVEL = 16,
  parameter int LEVEL_SHIFT = 4
) (
  input  logic [7:0] sample_data,
  output symbol_t    symbol
);

  // Half a step is added before truncation so each symbol is centred on its level.
  localparam logic signed [9:0] C_OFFSET  = 10'((2 ** (LEVEL_SHIFT - 1)) - BLACK_LEVEL);
  localparam logic [9:0]        C_SYM_MAX = 10'((1 << SYMBOL_W) - 1);

  logic signed [9:0] w_t;
  logic [9:0]        w_level;

  // Offset, scale down, then clamp below black and above the top symbol.
  always_comb begin
    w_t     = $signed({2'b00, sample_data}) + C_OFFSET;
    w_level = 10'(w_t >>> LEVEL_SHIFT);
    if (w_t[9]) begin
      symbol = '0;
    end else if (w_level > C_SYM_MAX) begin
      symbol = '1;
    end else begin
      symbol = w_level[SYMBOL_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_symbol_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : video_symbol_decoder
//  Description : Recovers 4-bit data symbols from the active picture area of
//                the digitised luma stream and writes them to the input FIFO.
//                Framing is derived from registered hs_n / vs_n edges.
//                Optional build macro VDEC_TEST_PATTERN_EN replaces the FIFO
//                data with a per-frame incrementing symbol counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_symbol_decoder
  import datatape_pkg::*;
#(
  parameter int BLACK_LEVEL      = 16,
  parameter int LEVEL_SHIFT      = 4,
  parameter int H_SKIP           = 40,
  parameter int ACTIVE_SAMPLES   = 320,
  parameter int V_SKIP           = 20,
  parameter int ACTIVE_LINES     = 200,
  parameter int FIFO_FULL_THRESH = 508
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          sample_data,
  input  logic                sample_valid,
  input  logic                hs_n,
  input  logic                vs_n,
  output logic [SYMBOL_W-1:0] fifow_data,
  output logic                fifow_request,
  input  logic [FIFO_AW-1:0]  fifow_used_words,
  output logic                frame_start,
  output logic                locked,
  output logic                overflow,
  output logic [15:0]         drop_count
);

  localparam logic [15:0]        C_V_LAST = 16'(V_SKIP - 1);
  localparam logic [15:0]        C_H_LAST = 16'(H_SKIP - 1);
  localparam logic [15:0]        C_A_LAST = 16'(ACTIVE_SAMPLES - 1);
  localparam logic [15:0]        C_L_LAST = 16'(ACTIVE_LINES - 1);
  localparam logic [FIFO_AW-1:0] C_FULL   = FIFO_AW'(FIFO_FULL_THRESH);

  dec_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] line_q, line_d;

  // Sync registers idle high so reset release never looks like an edge.
  logic hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic vs_q, vs_d, vs_prev_q, vs_prev_d;

  logic          fifow_request_q, fifow_request_d;
  symbol_t       fifow_data_q, fifow_data_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          frame_clean_q, frame_clean_d;

  logic    w_hs_rise, w_vs_rise, w_vs_fall;
  logic    w_abort, w_take, w_full;
  logic    w_frame_begin, w_frame_end, w_short_line;
  symbol_t w_symbol_out;

  assign w_hs_rise = hs_q & ~hs_prev_q;
  assign w_vs_rise = vs_q & ~vs_prev_q;
  assign w_vs_fall = ~vs_q & vs_prev_q;

  // A vsync fall outranks any hsync edge in the same cycle.
  assign w_abort       = w_vs_fall && (state_q != IDLE);
  assign w_take        = (state_q == ACTIVE) && sample_valid && !w_hs_rise && !w_abort;
  assign w_full        = fifow_used_words >= C_FULL;
  assign w_frame_begin = (state_q == VSKIP) && w_hs_rise && (cnt_q == C_V_LAST) && !w_abort;
  assign w_frame_end   = (state_q == LINE_END) && w_hs_rise && (line_q == C_L_LAST) && !w_abort;
  assign w_short_line  = (state_q == ACTIVE) && w_hs_rise && !w_abort;

`ifdef VDEC_TEST_PATTERN_EN
  symbol_t pat_q, pat_d;

  // Pattern counter restarts each frame and advances per produced symbol, dropped or not.
  always_comb begin
    pat_d = pat_q;
    if (w_frame_begin) begin
      pat_d = '0;
    end else if (w_take) begin
      pat_d = pat_q + symbol_t'(1);
    end
  end

  // Pattern counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign w_symbol_out = pat_q;
`else
  video_symbol_quantizer #(
    .BLACK_LEVEL (BLACK_LEVEL),
    .LEVEL_SHIFT (LEVEL_SHIFT)
  ) u_quantizer (
    .sample_data (sample_data),
    .symbol      (w_symbol_out)
  );
`endif

  // State register plus the line/position counters that travel with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next-state: framing sequence from vsync through skip, capture and line end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    if (w_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      line_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_vs_rise) begin
            state_d = VSKIP;
            cnt_d   = '0;
          end
        end
        VSKIP: begin
          if (w_hs_rise) begin
            if (cnt_q == C_V_LAST) begin
              state_d = HSKIP;
              cnt_d   = '0;
              line_d  = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        HSKIP: begin
          if (sample_valid) begin
            if (cnt_q == C_H_LAST) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ACTIVE: begin
          // An early hsync closes the line short; the frame continues.
          if (w_hs_rise) begin
            cnt_d = '0;
            if (line_q == C_L_LAST) begin
              state_d = IDLE;
              line_d  = '0;
            end else begin
              state_d = HSKIP;
              line_d  = line_q + 16'd1;
            end
          end else if (sample_valid) begin
            if (cnt_q == C_A_LAST) begin
              state_d = LINE_END;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        LINE_END: begin
          if (w_hs_rise) begin
            cnt_d = '0;
            if (line_q == C_L_LAST) begin
              state_d = IDLE;
              line_d  = '0;
            end else begin
              state_d = HSKIP;
              line_d  = line_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          line_d  = '0;
        end
      endcase
    end
  end

  // Outputs: FIFO write or drop accounting, frame pulse and lock tracking.
  always_comb begin
    hs_d            = hs_n;
    hs_prev_d       = hs_q;
    vs_d            = vs_n;
    vs_prev_d       = vs_q;
    fifow_request_d = w_take && !w_full;
    fifow_data_d    = (w_take && !w_full) ? w_symbol_out : fifow_data_q;
    frame_start_d   = w_frame_begin;
    overflow_d      = overflow_q | (w_take && w_full);
    drop_count_d    = drop_count_q;
    if (w_take && w_full && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    frame_clean_d = frame_clean_q;
    if (w_frame_begin) begin
      frame_clean_d = 1'b1;
    end else if (w_short_line) begin
      frame_clean_d = 1'b0;
    end
    locked_d = locked_q;
    if (w_abort || w_short_line) begin
      locked_d = 1'b0;
    end else if (w_frame_end && frame_clean_q) begin
      locked_d = 1'b1;
    end
  end

  // Sync pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q            <= 1'b1;
      hs_prev_q       <= 1'b1;
      vs_q            <= 1'b1;
      vs_prev_q       <= 1'b1;
      fifow_request_q <= 1'b0;
      fifow_data_q    <= '0;
      frame_start_q   <= 1'b0;
      locked_q        <= 1'b0;
      overflow_q      <= 1'b0;
      drop_count_q    <= '0;
      frame_clean_q   <= 1'b0;
    end else begin
      hs_q            <= hs_d;
      hs_prev_q       <= hs_prev_d;
      vs_q            <= vs_d;
      vs_prev_q       <= vs_prev_d;
      fifow_request_q <= fifow_request_d;
      fifow_data_q    <= fifow_data_d;
      frame_start_q   <= frame_start_d;
      locked_q        <= locked_d;
      overflow_q      <= overflow_d;
      drop_count_q    <= drop_count_d;
      frame_clean_q   <= frame_clean_d;
    end
  end

  assign fifow_request = fifow_request_q;
  assign fifow_data    = fifow_data_q;
  assign frame_start   = frame_start_q;
  assign locked        = locked_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_video_symbol_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_symbol_decoder
//  Description : Directed self-checking bench for video_symbol_decoder with a
//                reduced geometry (2 skip lines, 2 skip samples, 4x8 active).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_symbol_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic       sample_valid = 1'b0;
  logic       hs_n = 1'b1;
  logic       vs_n = 1'b1;
  logic [3:0] fifow_data;
  logic       fifow_request;
  logic [8:0] fifow_used_words = 9'd0;
  logic       frame_start;
  logic       locked;
  logic       overflow;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int fs_cnt   = 0;
  int exp_pat  = 0;

  always #5 clk = ~clk;

  video_symbol_decoder #(
    .BLACK_LEVEL      (16),
    .LEVEL_SHIFT      (4),
    .H_SKIP           (2),
    .ACTIVE_SAMPLES   (8),
    .V_SKIP           (2),
    .ACTIVE_LINES     (4),
    .FIFO_FULL_THRESH (508)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid),
    .hs_n             (hs_n),
    .vs_n             (vs_n),
    .fifow_data       (fifow_data),
    .fifow_request    (fifow_request),
    .fifow_used_words (fifow_used_words),
    .frame_start      (frame_start),
    .locked           (locked),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected symbol: round((s-16)/16) clamped to 0..15.
  function automatic logic [3:0] qmodel(input int s);
    int k;
    if (s < 8) return 4'd0;
    k = (s - 8) / 16;
    if (k > 15) k = 15;
    return 4'(k);
  endfunction

  // One clock: apply inputs, let the edge consume them, then inspect outputs.
  task automatic step(input bit v, input int d, input int used, input bit er, input logic [3:0] ed);
    sample_valid     = v;
    sample_data      = 8'(d);
    fifow_used_words = 9'(used);
    @(posedge clk);
    #1;
    check("req", fifow_request, er);
    if (er) check("data", fifow_data, ed);
    if (fifow_request) wr_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic hs_pulse();
    hs_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    hs_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
  endtask

  // Sync pulse followed by a few samples that must never be captured.
  task automatic blank_line();
    hs_pulse();
    for (int i = 0; i < 4; i++) step(1, 200, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic vsync();
    vs_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    vs_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
  endtask

  // Line: back porch with a hold gap, n samples (first n_full at FIFO threshold).
  task automatic line(input int n, input int base, input bit cap, input int n_full);
    int v;
    int used;
    logic [3:0] es;
    hs_pulse();
    step(1, 255, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 255, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      v    = (base + i) & 255;
      used = (i < n_full) ? 508 : ((n_full > 0) ? 507 : 0);
`ifdef VDEC_TEST_PATTERN_EN
      es = 4'(exp_pat);
`else
      es = qmodel(v);
`endif
      step(1, v, used, cap && (used < 508), es);
      if (cap) exp_pat++;
      if (i == 3) step(0, 0, used, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic frame(input int base, input int short_idx, input int full_idx,
                       input bit exp_lock, input string tag);
    int w0;
    int f0;
    int expw;
    vsync();
    blank_line();
    exp_pat = 0;
    w0 = wr_cnt;
    f0 = fs_cnt;
    for (int l = 0; l < 4; l++)
      line((l == short_idx) ? 3 : 8, base + 8 * l, 1, (l == full_idx) ? 5 : 0);
    blank_line();
    expw = 32 - ((short_idx >= 0) ? 5 : 0) - ((full_idx >= 0) ? 5 : 0);
    check({tag, "_writes"}, wr_cnt - w0, expw);
    check({tag, "_frame_start"}, fs_cnt - f0, 1);
    check({tag, "_locked"}, locked, exp_lock);
  endtask

  initial begin
    int w0;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", fifow_request, 0);
    check("rst_data", fifow_data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0..255 over eight frames; first frame also checks lock timing.
    vsync();
    blank_line();
    exp_pat = 0;
    w0 = wr_cnt;
    for (int l = 0; l < 4; l++) line(8, 8 * l, 1, 0);
    check("f0_locked_pre", locked, 0);
    blank_line();
    check("f0_writes", wr_cnt - w0, 32);
    check("f0_frame_start", fs_cnt, 1);
    check("f0_locked", locked, 1);
    for (int f = 1; f < 8; f++) frame(32 * f, -1, -1, 1, "ramp");

    // Short second line: 3 writes, lock lost for this frame.
    frame(100, 1, -1, 0, "short");
    frame(60, -1, -1, 1, "relock");

    // FIFO full during five samples of line 1.
    frame(150, -1, 1, 1, "full");
    check("ovf", overflow, 1);
    check("drop_count", drop_count, 5);

    // vsync falls mid line 2.
    vsync();
    blank_line();
    exp_pat = 0;
    w0 = wr_cnt;
    line(8, 0, 1, 0);
    line(8, 8, 1, 0);
    line(4, 16, 1, 0);
    vs_n = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 180, 0, 0, 0);
    check("abort_locked", locked, 0);
    line(8, 0, 0, 0);
    line(8, 0, 0, 0);
    check("abort_writes", wr_cnt - w0, 20);
    frame(200, -1, -1, 1, "post_abort");

    // Reset asserted mid ACTIVE with a write on the output.
    vsync();
    blank_line();
    exp_pat = 0;
    line(4, 40, 1, 0);
`ifdef VDEC_TEST_PATTERN_EN
    step(1, 255, 0, 1, 4'(exp_pat));
`else
    step(1, 255, 0, 1, 4'd15);
`endif
    #2 rst = 1'b0;
    #1;
    check("arst_req", fifow_request, 0);
    check("arst_data", fifow_data, 0);
    check("arst_locked", locked, 0);
    check("arst_ovf", overflow, 0);
    check("arst_drop", drop_count, 0);
    check("arst_fs", frame_start, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    w0 = wr_cnt;
    line(8, 0, 0, 0);
    line(8, 0, 0, 0);
    check("post_rst_writes", wr_cnt - w0, 0);
    frame(8, -1, -1, 1, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
